nonoverlap_phase_gen: RTL

Upstream driver for the ripple counter's two-phase inputs. Generates registered, non-overlapping eclk/ieclk pulse pairs from one system clock, replacing hand-timed bench stimulus. Supports a counted burst of N pulse pairs or free-running operation, with busy/done status for a controlling sequencer.

---
 rtl/nonoverlap_pkg.sv | 26 ++
 rtl/nonoverlap_phase_gen_phase_timer.sv | 32 +++
 rtl/nonoverlap_phase_gen.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nonoverlap_pkg.sv
// Shared state encoding and defaults for the two-phase non-overlapping pulse generator.
// The PRE/PRE_GAP counter-reset prologue states exist only when CNT_RST_EN is defined.
package nonoverlap_pkg;

  localparam int DEF_HI_CYC  = 3;
  localparam int DEF_GAP_CYC = 6;
  localparam int DEF_CW      = 8;
  localparam int TIMER_W     = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef CNT_RST_EN
    PRE     = 3'd1,
    PRE_GAP = 3'd2,
`endif
    P1      = 3'd3,
    G1      = 3'd4,
    P2      = 3'd5,
    G2      = 3'd6
  } state_t;

  function automatic int period_cyc(input int hi_cyc, input int gap_cyc);
    return 2 * (hi_cyc + gap_cyc);
  endfunction

endpackage

// File: rtl/nonoverlap_phase_gen_phase_timer.sv
// Loadable down-counter timing each phase; expire strobes for one cycle when a
// loaded interval of (load_val + 1) cycles has elapsed.
module phase_timer
  import nonoverlap_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count;
  logic               run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      run   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      run   <= 1'b1;
    end else if (run) begin
      if (count == '0) run <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  // run gates the strobe so an idle timer parked at zero stays quiet
  assign expire = run && (count == '0);

endmodule

// File: rtl/nonoverlap_phase_gen.sv
// Registered non-overlapping eclk/ieclk pulse-pair generator with counted or free-running bursts.
// Optional CNT_RST_EN adds a cnt_rst pulse and gap ahead of the first eclk.
module nonoverlap_phase_gen
  import nonoverlap_pkg::*;
#(
  parameter int HI_CYC  = DEF_HI_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [CW-1:0] burst_len,
  output logic          eclk,
  output logic          ieclk,
  output logic          cnt_rst,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pulse_cnt
);

  localparam logic [TIMER_W-1:0] HI_LOAD  = TIMER_W'(HI_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYC - 1);

  state_t             state;
  logic [CW-1:0]      len;
  logic [CW-1:0]      next_cnt;
  logic               accept;
  logic               finish;
  logic               expire;
  logic               load;
  logic [TIMER_W-1:0] load_val;

`ifdef CNT_RST_EN
  logic cnt_rst_q;
  assign cnt_rst = cnt_rst_q;
`else
  assign cnt_rst = 1'b0;
`endif

  assign accept   = (state == IDLE) && start && en;
  assign next_cnt = pulse_cnt + 1'b1;
  assign finish   = ((len != '0) && (next_cnt == len)) || !en;

  // Timer reload on every state entry: pulse states run HI_CYC, gap states GAP_CYC
  always_comb begin
    load     = 1'b0;
    load_val = HI_LOAD;
    case (state)
      IDLE: load = accept;
`ifdef CNT_RST_EN
      PRE: begin
        load     = expire;
        load_val = GAP_LOAD;
      end
`endif
      P1, P2: begin
        load     = expire;
        load_val = GAP_LOAD;
      end
      default: load = expire;
    endcase
  end

  phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      eclk      <= 1'b0;
      ieclk     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      len       <= '0;
`ifdef CNT_RST_EN
      cnt_rst_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            len       <= burst_len;
            pulse_cnt <= '0;
            busy      <= 1'b1;
`ifdef CNT_RST_EN
            state     <= PRE;
            cnt_rst_q <= 1'b1;
`else
            state     <= P1;
            eclk      <= 1'b1;
`endif
          end
        end
`ifdef CNT_RST_EN
        PRE: if (expire) begin
          cnt_rst_q <= 1'b0;
          state     <= PRE_GAP;
        end
        PRE_GAP: if (expire) begin
          eclk  <= 1'b1;
          state <= P1;
        end
`endif
        P1: if (expire) begin
          eclk  <= 1'b0;
          state <= G1;
        end
        G1: if (expire) begin
          ieclk <= 1'b1;
          state <= P2;
        end
        P2: if (expire) begin
          ieclk <= 1'b0;
          state <= G2;
        end
        // Period boundary: the only point where a burst may end
        G2: if (expire) begin
          pulse_cnt <= next_cnt;
          if (finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            eclk  <= 1'b1;
            state <= P1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
